pio_mem_init_arb: RTL and testbench
===================================

# pio_mem_init_arb

Controller for the application side of a PIO-accessible BRAM with one read port, one write port and a 1-cycle ack.
- After reset, or on request, it scrubs every word to a constant.
- It then shares the read port between two read clients A and B, round-robin.
- It passes one write client through and routes returned read data to the client that issued the read.
- It stalls any read that would race an in-flight write to the same address.

## Interface
- WIDTH, 20, data width.
- DEPTH_NBITS, 10, address width; the memory holds 2^DEPTH_NBITS words.
- INIT_VAL, 0, value written to every word during scrub.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- init_start  in  1  pulse; starts a re-scrub (accepted only in RUN).
- init_busy  out  1  high while in INIT.
- init_done  out  1  1-cycle pulse when a scrub completes.
- a_rd_req, b_rd_req  in  1  read requests; each is held with its address until granted.
- a_rd_addr, b_rd_addr  in  DEPTH_NBITS  read addresses.
- a_rd_gnt, b_rd_gnt  out  1  combinational grants; a request is consumed in a cycle where req and gnt are both high.
- a_rd_valid, b_rd_valid  out  1  1-cycle read-data strobe.
- a_rd_data, b_rd_data  out  WIDTH  read data; valid only with the matching strobe.
- w_req  in  1  write request.
- w_addr  in  DEPTH_NBITS  write address.
- w_data  in  WIDTH  write data.
- w_gnt  out  1  combinational write grant.
- mem_rd, mem_raddr  out  1 / DEPTH_NBITS  registered read command to the memory.
- mem_wr, mem_waddr, mem_wdata  out  1 / DEPTH_NBITS / WIDTH  registered write command to the memory.
- mem_ack  in  1  read ack; arrives one cycle after mem_rd.
- mem_rdata  in  WIDTH  memory read data; valid with mem_ack.

## Operation
States: INIT and RUN. Reset puts the block in INIT with the scrub counter at 0.

INIT:
- Each cycle: mem_wr=1, mem_waddr=cnt, mem_wdata=INIT_VAL, then cnt++.
- When cnt reaches 2^DEPTH_NBITS-1, that last write issues, state goes to RUN and init_done pulses.
- All grants are 0. init_start is ignored.

RUN, writes:
- w_gnt = w_req.
- The next cycle: mem_wr=1 with the granted address and data.

RUN, reads:
- Grant at most one read client per cycle.
- If both A and B request, grant the client not granted most recently. The round-robin pointer resets to favour A.
- If only one requests, grant it, subject to the hazard rule below.
- Granted read: mem_rd=1 and mem_raddr=addr the next cycle. A 1-bit tag records A or B.

Hazard rule:
- The memory commits a write two cycles after this block's grant, and the read is read-first.
- So a read is not granted if its address equals w_addr of a write granted in the same cycle, or the address of a write granted in the previous cycle. Scrub writes count as writes.
- The blocked client keeps holding its request. The other client may be granted that cycle if it is hazard-free.

Return path:
- On mem_ack, the tag registered with mem_rd selects the client.
- That client's rd_valid is driven high with rd_data=mem_rdata in the same cycle, with no added register.
- The tag is delayed to align with mem_ack.

RUN to INIT:
- init_start in RUN goes to INIT next cycle with cnt=0.
- Grants in that same cycle are still honoured, and in-flight reads complete and return normally.

Errors:
- mem_ack with no outstanding read is dropped.

Reset behaviour:
- rst mid-operation drops all in-flight reads; no rd_valid is issued for them. The block restarts the scrub.

Reset values:
- mem_rd=0, mem_wr=0, mem_raddr=0, mem_waddr=0, mem_wdata=0.
- init_busy=1, init_done=0.
- Round-robin pointer favours A.
- Tags and valids cleared.

## Timing
- First scrub write is on mem_wr in the 1st cycle after rst drops. The scrub lasts exactly 2^DEPTH_NBITS cycles.
- init_done coincides with the first RUN cycle, in which grants are possible.
- Read: gnt in cycle T, mem_rd in T+1, mem_ack and rd_valid in T+2. Throughput is one read per cycle.
- Write: gnt in cycle T, mem_wr in T+1. Reads and writes may be granted in the same cycle.
- Hazard window: a read to the address of a write granted in cycle W is first grantable in W+2.

## Test plan
- Reset with DEPTH_NBITS=4, INIT_VAL=0x5A -> mem_wr high for 16 consecutive cycles with addresses 0..15 and data 0x5A. init_done pulses once. No grants are issued before it.
- A and B both request continuously at addresses 3 and 7 -> grants alternate A,B,A,B starting with A. rd_valid alternates two cycles behind each grant, with the correct data routed to each client.
- Write 0x123 to address 5 granted in cycle W, with A reading address 5 from W -> a_rd_gnt is 0 in W and W+1 and 1 in W+2. a_rd_data returns 0x123.
- Same as the previous case, but B reads address 6 while A is blocked -> B is granted in W. A is granted in W+2.
- init_start while B reads are in flight -> those reads still return valid data. Scrub writes start the next cycle. No grants until init_done.
- rst asserted one cycle after an A grant -> no a_rd_valid is issued. All outputs return to their reset values. The scrub restarts at address 0.

Source files
------------

// File: rtl/pio_mem_init_arb_if.sv
// -----------------------------------------------------------------------------
// pio_mem_init_arb_if
// Bundles every handshake and memory-command signal of pio_mem_init_arb.
//   init_start/init_busy/init_done : scrub control and status
//   a_rd_* / b_rd_*                : two read clients (req/addr/gnt/valid/data)
//   w_*                            : one write client (req/addr/data/gnt)
//   mem_*                          : registered read/write commands to the BRAM
//                                    and its read ack/data
// Modports:
//   slave  - the controller (pio_mem_init_arb)
//   master - the environment: clients plus the memory
// -----------------------------------------------------------------------------
interface pio_mem_init_arb_if #(
  parameter int WIDTH       = 20,
  parameter int DEPTH_NBITS = 10
);
  logic                   init_start;
  logic                   init_busy;
  logic                   init_done;

  logic                   a_rd_req;
  logic [DEPTH_NBITS-1:0] a_rd_addr;
  logic                   a_rd_gnt;
  logic                   a_rd_valid;
  logic [WIDTH-1:0]       a_rd_data;

  logic                   b_rd_req;
  logic [DEPTH_NBITS-1:0] b_rd_addr;
  logic                   b_rd_gnt;
  logic                   b_rd_valid;
  logic [WIDTH-1:0]       b_rd_data;

  logic                   w_req;
  logic [DEPTH_NBITS-1:0] w_addr;
  logic [WIDTH-1:0]       w_data;
  logic                   w_gnt;

  logic                   mem_rd;
  logic [DEPTH_NBITS-1:0] mem_raddr;
  logic                   mem_wr;
  logic [DEPTH_NBITS-1:0] mem_waddr;
  logic [WIDTH-1:0]       mem_wdata;
  logic                   mem_ack;
  logic [WIDTH-1:0]       mem_rdata;

  modport slave (
    input  init_start,
    output init_busy, init_done,
    input  a_rd_req, a_rd_addr,
    output a_rd_gnt, a_rd_valid, a_rd_data,
    input  b_rd_req, b_rd_addr,
    output b_rd_gnt, b_rd_valid, b_rd_data,
    input  w_req, w_addr, w_data,
    output w_gnt,
    output mem_rd, mem_raddr, mem_wr, mem_waddr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output init_start,
    input  init_busy, init_done,
    output a_rd_req, a_rd_addr,
    input  a_rd_gnt, a_rd_valid, a_rd_data,
    output b_rd_req, b_rd_addr,
    input  b_rd_gnt, b_rd_valid, b_rd_data,
    output w_req, w_addr, w_data,
    input  w_gnt,
    input  mem_rd, mem_raddr, mem_wr, mem_waddr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/pio_mem_init_arb.sv
// -----------------------------------------------------------------------------
// pio_mem_init_arb
// Application-side controller for a BRAM with one read port, one write port
// and a 1-cycle read ack. After reset (or init_start in RUN) every word is
// scrubbed to INIT_VAL; afterwards two read clients share the read port
// round-robin, one write client passes straight through, and read data is
// routed back to the client that issued the read.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - pio_mem_init_arb_if.slave: scrub control, read clients A/B,
//          write client, registered memory commands, memory ack/data
// -----------------------------------------------------------------------------
module pio_mem_init_arb #(
  parameter int               WIDTH       = 20,
  parameter int               DEPTH_NBITS = 10,
  parameter logic [WIDTH-1:0] INIT_VAL    = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  pio_mem_init_arb_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [DEPTH_NBITS-1:0] CNT_LAST = {DEPTH_NBITS{1'b1}};
  localparam logic [DEPTH_NBITS-1:0] CNT_ONE  = DEPTH_NBITS'(1);

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [DEPTH_NBITS-1:0] cnt_r;
  logic                   init_busy_r;
  logic                   init_done_r;

  logic                   rr_favour_b_r;   // 1: B wins the next A/B tie
  logic                   mem_rd_r;
  logic [DEPTH_NBITS-1:0] mem_raddr_r;
  logic                   rd_tag_r;        // travels with mem_rd: 0=A, 1=B
  logic                   ack_pend_r;      // a read is due back this cycle
  logic                   ack_tag_r;       // rd_tag_r delayed to line up with mem_ack

  logic                   mem_wr_r;
  logic [DEPTH_NBITS-1:0] mem_waddr_r;
  logic [WIDTH-1:0]       mem_wdata_r;

  logic                   in_run_s;
  logic                   scrub_last_s;
  logic                   haz_a_s;
  logic                   haz_b_s;
  logic                   a_ok_s;
  logic                   b_ok_s;
  logic                   a_gnt_s;
  logic                   b_gnt_s;
  logic                   w_gnt_s;
  logic                   a_valid_s;
  logic                   b_valid_s;

  assign in_run_s     = (state_r == ST_RUN);
  assign scrub_last_s = (state_r == ST_INIT) && (cnt_r == CNT_LAST);

  // A write commits two cycles after its grant and reads are read-first, so
  // a read must not overlap a write granted this cycle (w_req in RUN) or the
  // one granted last cycle (now visible on mem_wr, scrub writes included).
  assign haz_a_s = (bus.w_req && in_run_s && (bus.a_rd_addr == bus.w_addr)) ||
                   (mem_wr_r && (bus.a_rd_addr == mem_waddr_r));
  assign haz_b_s = (bus.w_req && in_run_s && (bus.b_rd_addr == bus.w_addr)) ||
                   (mem_wr_r && (bus.b_rd_addr == mem_waddr_r));

  assign a_ok_s  = in_run_s && bus.a_rd_req && !haz_a_s;
  assign b_ok_s  = in_run_s && bus.b_rd_req && !haz_b_s;
  assign w_gnt_s = in_run_s && bus.w_req;

  // Read arbitration: round-robin on a tie, otherwise any hazard-free client.
  always_comb begin
    a_gnt_s = 1'b0;
    b_gnt_s = 1'b0;
    if (a_ok_s && b_ok_s) begin
      if (rr_favour_b_r) begin
        b_gnt_s = 1'b1;
      end else begin
        a_gnt_s = 1'b1;
      end
    end else if (a_ok_s) begin
      a_gnt_s = 1'b1;
    end else if (b_ok_s) begin
      b_gnt_s = 1'b1;
    end else begin
      a_gnt_s = 1'b0;
      b_gnt_s = 1'b0;
    end
  end

  // Next-state logic for the INIT/RUN controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (bus.init_start) begin
          state_nxt_s = ST_INIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // State register, scrub counter and scrub status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      cnt_r       <= {DEPTH_NBITS{1'b0}};
      init_busy_r <= 1'b1;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      // The counter wraps to 0 on the last scrub write and stays 0 in RUN,
      // so every re-scrub starts at address 0.
      if (state_r == ST_INIT) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= {DEPTH_NBITS{1'b0}};
      end
      init_busy_r <= (state_nxt_s == ST_INIT);
      init_done_r <= scrub_last_s;
    end
  end

  // Registered write command: scrub word in INIT, granted client write in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wr_r    <= 1'b0;
      mem_waddr_r <= {DEPTH_NBITS{1'b0}};
      mem_wdata_r <= {WIDTH{1'b0}};
    end else if (state_r == ST_INIT) begin
      mem_wr_r    <= 1'b1;
      mem_waddr_r <= cnt_r;
      mem_wdata_r <= INIT_VAL;
    end else if (w_gnt_s) begin
      mem_wr_r    <= 1'b1;
      mem_waddr_r <= bus.w_addr;
      mem_wdata_r <= bus.w_data;
    end else begin
      mem_wr_r    <= 1'b0;
    end
  end

  // Registered read command, client tag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_r      <= 1'b0;
      mem_raddr_r   <= {DEPTH_NBITS{1'b0}};
      rd_tag_r      <= 1'b0;
      rr_favour_b_r <= 1'b0;
    end else begin
      mem_rd_r <= a_gnt_s || b_gnt_s;
      rd_tag_r <= b_gnt_s;
      if (a_gnt_s) begin
        mem_raddr_r   <= bus.a_rd_addr;
        rr_favour_b_r <= 1'b1;
      end else if (b_gnt_s) begin
        mem_raddr_r   <= bus.b_rd_addr;
        rr_favour_b_r <= 1'b0;
      end else begin
        mem_raddr_r   <= mem_raddr_r;
        rr_favour_b_r <= rr_favour_b_r;
      end
    end
  end

  // Align the tag with mem_ack; reset discards reads still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_pend_r <= 1'b0;
      ack_tag_r  <= 1'b0;
    end else begin
      ack_pend_r <= mem_rd_r;
      ack_tag_r  <= rd_tag_r;
    end
  end

  // An ack without a pending read matches neither client and is dropped.
  assign a_valid_s = bus.mem_ack && ack_pend_r && !ack_tag_r;
  assign b_valid_s = bus.mem_ack && ack_pend_r &&  ack_tag_r;

  assign bus.a_rd_gnt   = a_gnt_s;
  assign bus.b_rd_gnt   = b_gnt_s;
  assign bus.w_gnt      = w_gnt_s;
  assign bus.a_rd_valid = a_valid_s;
  assign bus.b_rd_valid = b_valid_s;
  assign bus.a_rd_data  = a_valid_s ? bus.mem_rdata : {WIDTH{1'b0}};
  assign bus.b_rd_data  = b_valid_s ? bus.mem_rdata : {WIDTH{1'b0}};
  assign bus.mem_rd     = mem_rd_r;
  assign bus.mem_raddr  = mem_raddr_r;
  assign bus.mem_wr     = mem_wr_r;
  assign bus.mem_waddr  = mem_waddr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.init_busy  = init_busy_r;
  assign bus.init_done  = init_done_r;

endmodule

// File: tb/tb_pio_mem_init_arb.sv
// -----------------------------------------------------------------------------
// tb_pio_mem_init_arb
// Directed bench for pio_mem_init_arb with a 16-word memory and INIT_VAL 0x5A.
// Inputs change 1 time unit after posedge; outputs are compared at negedge.
// A small read-first memory model answers mem_rd with mem_ack one cycle later.
// -----------------------------------------------------------------------------
module tb_pio_mem_init_arb;
  localparam int               WIDTH       = 20;
  localparam int               DEPTH_NBITS = 4;
  localparam logic [WIDTH-1:0] INIT_VAL    = 20'h0005A;

  logic clk;
  logic rst;
  logic inject_ack;
  int   checks;
  int   errors;
  int   done_pulses;

  logic [WIDTH-1:0] mem [0:15];

  pio_mem_init_arb_if #(.WIDTH(WIDTH), .DEPTH_NBITS(DEPTH_NBITS)) bus ();

  pio_mem_init_arb #(
    .WIDTH      (WIDTH),
    .DEPTH_NBITS(DEPTH_NBITS),
    .INIT_VAL   (INIT_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first memory model with a one-cycle ack; inject_ack forces a stray ack.
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_waddr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_raddr];
    bus.mem_ack   <= bus.mem_rd | inject_ack;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; done_pulses = 0;
    rst = 1'b1; inject_ack = 1'b0;
    bus.init_start = 1'b0;
    bus.a_rd_req = 1'b0; bus.a_rd_addr = 4'd0;
    bus.b_rd_req = 1'b0; bus.b_rd_addr = 4'd0;
    bus.w_req = 1'b0; bus.w_addr = 4'd0; bus.w_data = 20'h0;

    // Reset values
    cyc(); cyc(); settle();
    check_eq("rst_mem_wr",    32'(bus.mem_wr),    32'h0);
    check_eq("rst_mem_rd",    32'(bus.mem_rd),    32'h0);
    check_eq("rst_mem_waddr", 32'(bus.mem_waddr), 32'h0);
    check_eq("rst_mem_raddr", 32'(bus.mem_raddr), 32'h0);
    check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    check_eq("rst_init_busy", 32'(bus.init_busy), 32'h1);
    check_eq("rst_init_done", 32'(bus.init_done), 32'h0);

    // Scrub: requests held from the start must not be granted before init_done
    cyc();
    rst = 1'b0;
    bus.b_rd_req = 1'b1; bus.b_rd_addr = 4'd7;
    bus.w_req = 1'b1; bus.w_addr = 4'd3; bus.w_data = 20'h00111;
    settle();
    check_eq("scrub_c0_mem_wr", 32'(bus.mem_wr), 32'h0);
    check_eq("scrub_c0_b_gnt", 32'(bus.b_rd_gnt), 32'h0);
    for (int i = 0; i < 16; i++) begin
      cyc(); settle();
      check_eq("scrub_mem_wr",    32'(bus.mem_wr),    32'h1);
      check_eq("scrub_mem_waddr", 32'(bus.mem_waddr), 32'(i));
      check_eq("scrub_mem_wdata", 32'(bus.mem_wdata), 32'h5A);
      if (bus.init_done) done_pulses++;
      if (i < 15) begin
        check_eq("scrub_b_gnt", 32'(bus.b_rd_gnt), 32'h0);
        check_eq("scrub_w_gnt", 32'(bus.w_gnt), 32'h0);
        check_eq("scrub_busy",  32'(bus.init_busy), 32'h1);
      end else begin
        check_eq("run0_init_done", 32'(bus.init_done), 32'h1);
        check_eq("run0_busy",      32'(bus.init_busy), 32'h0);
        check_eq("run0_b_gnt",     32'(bus.b_rd_gnt), 32'h1);
        check_eq("run0_a_gnt",     32'(bus.a_rd_gnt), 32'h0);
        check_eq("run0_w_gnt",     32'(bus.w_gnt), 32'h1);
      end
    end
    cyc();
    bus.b_rd_req = 1'b0;
    bus.w_addr = 4'd7; bus.w_data = 20'h00222;
    settle();
    if (bus.init_done) done_pulses++;
    check_eq("done_pulses", 32'(done_pulses), 32'h1);
    check_eq("rd_cmd_mem_rd",    32'(bus.mem_rd),    32'h1);
    check_eq("rd_cmd_mem_raddr", 32'(bus.mem_raddr), 32'h7);
    check_eq("wr_cmd_waddr",     32'(bus.mem_waddr), 32'h3);
    check_eq("wr_cmd_wdata",     32'(bus.mem_wdata), 32'h111);
    check_eq("wr2_w_gnt",        32'(bus.w_gnt),     32'h1);
    cyc();
    bus.w_req = 1'b0;
    settle();
    check_eq("b_scrub_valid", 32'(bus.b_rd_valid), 32'h1);
    check_eq("b_scrub_data",  32'(bus.b_rd_data),  32'h5A);
    check_eq("b_scrub_a_vld", 32'(bus.a_rd_valid), 32'h0);

    // Stray ack with nothing outstanding is dropped
    cyc();
    inject_ack = 1'b1;
    cyc();
    inject_ack = 1'b0;
    settle();
    check_eq("stray_ack_a", 32'(bus.a_rd_valid), 32'h0);
    check_eq("stray_ack_b", 32'(bus.b_rd_valid), 32'h0);

    // Round-robin: A@3 (0x111) and B@7 (0x222) both requesting
    for (int k = 0; k < 6; k++) begin
      cyc();
      bus.a_rd_req = (k < 4); bus.a_rd_addr = 4'd3;
      bus.b_rd_req = (k < 4); bus.b_rd_addr = 4'd7;
      settle();
      if (k < 4) begin
        check_eq("rr_a_gnt", 32'(bus.a_rd_gnt), 32'(k % 2 == 0));
        check_eq("rr_b_gnt", 32'(bus.b_rd_gnt), 32'(k % 2 == 1));
      end
      if (k >= 2) begin
        check_eq("rr_a_valid", 32'(bus.a_rd_valid), 32'(k % 2 == 0));
        check_eq("rr_b_valid", 32'(bus.b_rd_valid), 32'(k % 2 == 1));
        if (k % 2 == 0) check_eq("rr_a_data", 32'(bus.a_rd_data), 32'h111);
        else            check_eq("rr_b_data", 32'(bus.b_rd_data), 32'h222);
      end
    end

    // Hazard: write 0x123 @5 in W, A reads @5 from W
    cyc();
    bus.w_req = 1'b1; bus.w_addr = 4'd5; bus.w_data = 20'h00123;
    bus.a_rd_req = 1'b1; bus.a_rd_addr = 4'd5;
    settle();
    check_eq("haz_w_a_gnt", 32'(bus.a_rd_gnt), 32'h0);
    check_eq("haz_w_w_gnt", 32'(bus.w_gnt), 32'h1);
    cyc();
    bus.w_req = 1'b0;
    settle();
    check_eq("haz_w1_a_gnt", 32'(bus.a_rd_gnt), 32'h0);
    cyc(); settle();
    check_eq("haz_w2_a_gnt", 32'(bus.a_rd_gnt), 32'h1);
    cyc();
    bus.a_rd_req = 1'b0;
    settle();
    check_eq("haz_mem_rd", 32'(bus.mem_rd), 32'h1);
    cyc(); settle();
    check_eq("haz_a_valid", 32'(bus.a_rd_valid), 32'h1);
    check_eq("haz_a_data",  32'(bus.a_rd_data),  32'h123);

    // Hazard with B@6 free: write 0x0CD @5, A blocked, B granted in W
    cyc();
    bus.w_req = 1'b1; bus.w_addr = 4'd5; bus.w_data = 20'h000CD;
    bus.a_rd_req = 1'b1; bus.a_rd_addr = 4'd5;
    bus.b_rd_req = 1'b1; bus.b_rd_addr = 4'd6;
    settle();
    check_eq("hazb_w_a_gnt", 32'(bus.a_rd_gnt), 32'h0);
    check_eq("hazb_w_b_gnt", 32'(bus.b_rd_gnt), 32'h1);
    cyc();
    bus.w_req = 1'b0; bus.b_rd_req = 1'b0;
    settle();
    check_eq("hazb_w1_a_gnt", 32'(bus.a_rd_gnt), 32'h0);
    cyc(); settle();
    check_eq("hazb_w2_a_gnt", 32'(bus.a_rd_gnt), 32'h1);
    check_eq("hazb_b_valid",  32'(bus.b_rd_valid), 32'h1);
    check_eq("hazb_b_data",   32'(bus.b_rd_data),  32'h5A);
    cyc();
    bus.a_rd_req = 1'b0;
    cyc(); settle();
    check_eq("hazb_a_valid", 32'(bus.a_rd_valid), 32'h1);
    check_eq("hazb_a_data",  32'(bus.a_rd_data),  32'h0CD);

    // init_start with a B read in flight
    cyc();
    bus.b_rd_req = 1'b1; bus.b_rd_addr = 4'd7;
    bus.init_start = 1'b1;
    settle();
    check_eq("istart_b_gnt", 32'(bus.b_rd_gnt), 32'h1);
    check_eq("istart_busy",  32'(bus.init_busy), 32'h0);
    cyc();
    bus.init_start = 1'b0; bus.b_rd_addr = 4'd6;
    settle();
    check_eq("reinit_busy",   32'(bus.init_busy), 32'h1);
    check_eq("reinit_b_gnt",  32'(bus.b_rd_gnt), 32'h0);
    check_eq("reinit_mem_rd", 32'(bus.mem_rd), 32'h1);
    check_eq("reinit_raddr",  32'(bus.mem_raddr), 32'h7);
    check_eq("reinit_mem_wr", 32'(bus.mem_wr), 32'h0);
    for (int i = 0; i < 16; i++) begin
      cyc(); settle();
      check_eq("reinit_scrub_wr",    32'(bus.mem_wr),    32'h1);
      check_eq("reinit_scrub_waddr", 32'(bus.mem_waddr), 32'(i));
      if (i == 0) begin
        check_eq("reinit_b_valid", 32'(bus.b_rd_valid), 32'h1);
        check_eq("reinit_b_data",  32'(bus.b_rd_data),  32'h222);
      end
      if (i < 15) begin
        check_eq("reinit_b_gnt_blk", 32'(bus.b_rd_gnt), 32'h0);
        check_eq("reinit_done_lo",   32'(bus.init_done), 32'h0);
      end else begin
        check_eq("reinit_done_hi", 32'(bus.init_done), 32'h1);
        check_eq("reinit_b_gnt",   32'(bus.b_rd_gnt), 32'h1);
      end
    end
    cyc();
    bus.b_rd_req = 1'b0;
    cyc(); settle();
    check_eq("reinit_b6_valid", 32'(bus.b_rd_valid), 32'h1);
    check_eq("reinit_b6_data",  32'(bus.b_rd_data),  32'h5A);

    // Reset one cycle after an A grant drops the read
    cyc();
    bus.a_rd_req = 1'b1; bus.a_rd_addr = 4'd3;
    settle();
    check_eq("rstmid_a_gnt", 32'(bus.a_rd_gnt), 32'h1);
    cyc();
    bus.a_rd_req = 1'b0; rst = 1'b1;
    settle();
    check_eq("rstmid_mem_rd", 32'(bus.mem_rd), 32'h1);
    cyc();
    rst = 1'b0;
    settle();
    check_eq("rstmid_a_valid", 32'(bus.a_rd_valid), 32'h0);
    check_eq("rstmid_mem_rd0", 32'(bus.mem_rd),     32'h0);
    check_eq("rstmid_raddr",   32'(bus.mem_raddr),  32'h0);
    check_eq("rstmid_mem_wr",  32'(bus.mem_wr),     32'h0);
    check_eq("rstmid_waddr",   32'(bus.mem_waddr),  32'h0);
    check_eq("rstmid_wdata",   32'(bus.mem_wdata),  32'h0);
    check_eq("rstmid_busy",    32'(bus.init_busy),  32'h1);
    check_eq("rstmid_done",    32'(bus.init_done),  32'h0);
    cyc(); settle();
    check_eq("rstmid_scrub_wr",    32'(bus.mem_wr),    32'h1);
    check_eq("rstmid_scrub_waddr", 32'(bus.mem_waddr), 32'h0);
    check_eq("rstmid_scrub_wdata", 32'(bus.mem_wdata), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
